// File: rtl/ltl_auto_pkg.sv
// Shared types for the LTL automaton engine: start types, per-element
// configuration record and the empty (never-matching) reset configuration.
package ltl_auto_pkg;

  // Storage widths for one element; engine parameters must not exceed these.
  localparam int STE_SYM_W = 32;
  localparam int STE_MAX_N = 64;

  typedef enum logic [1:0] {
    START_NONE    = 2'd0,
    START_OF_DATA = 2'd1,
    START_ALL     = 2'd2
  } start_t;

  typedef struct packed {
    logic [STE_SYM_W-1:0] lo;
    logic [STE_SYM_W-1:0] hi;
    start_t               start;
    logic                 report;
    logic [STE_MAX_N-1:0] pred;
  } ste_cfg_t;

  localparam ste_cfg_t CFG_EMPTY = '{
    lo:     '1,
    hi:     '0,
    start:  START_NONE,
    report: 1'b0,
    pred:   '0
  };

  function automatic logic in_interval(input logic [STE_SYM_W-1:0] sym,
                                       input logic [STE_SYM_W-1:0] lo,
                                       input logic [STE_SYM_W-1:0] hi);
    return (sym >= lo) && (sym <= hi);
  endfunction

endpackage

// File: rtl/ltl_ste_cell.sv
// One state element: configuration register, interval match, enable OR over
// predecessors and the active flop.
module ltl_ste_cell
  import ltl_auto_pkg::*;
#(
  parameter int N_STATES = 16,
  parameter int SYMBOL_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                restart,
  input  logic                run,
  input  logic                start_of_data,
  input  logic [SYMBOL_W-1:0] symbols,
  input  logic                cfg_we,
  input  ste_cfg_t            cfg_wr,
  input  logic [N_STATES-1:0] active_vec,
  output logic                active,
  output logic                report_en
);

  ste_cfg_t cfg_q;
  logic     match;
  logic     en;

  // Start type 3 matches neither compare and therefore behaves as "none".
  always_comb begin
    match = in_interval(STE_SYM_W'(symbols), cfg_q.lo, cfg_q.hi);
    en    = (cfg_q.start == START_ALL)
          | ((cfg_q.start == START_OF_DATA) & start_of_data)
          | (|(cfg_q.pred & STE_MAX_N'(active_vec)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_q <= CFG_EMPTY;
    end else if (cfg_we) begin
      cfg_q <= cfg_wr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      active <= 1'b0;
    end else if (run) begin
      active <= match & en;
    end
  end

  assign report_en = cfg_q.report;

endmodule

// File: rtl/ltl_automata_engine.sv
// Homogeneous automaton engine: array of programmable state elements plus
// start-of-data flag, symbol counter, first-report capture and write decode.
module ltl_automata_engine
  import ltl_auto_pkg::*;
#(
  parameter int N_STATES = 16,
  parameter int SYMBOL_W = 8,
  parameter int CNT_W    = 32,
  localparam int ADDR_W  = $clog2(N_STATES)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [SYMBOL_W-1:0] symbols,
  input  logic                restart,
  input  logic                cfg_we,
  input  logic [ADDR_W-1:0]   cfg_addr,
  input  logic [SYMBOL_W-1:0] cfg_lo,
  input  logic [SYMBOL_W-1:0] cfg_hi,
  input  logic [1:0]          cfg_start,
  input  logic                cfg_report,
  input  logic [N_STATES-1:0] cfg_pred,
  output logic                cfg_err,
  output logic [N_STATES-1:0] active,
  output logic [N_STATES-1:0] report,
  output logic                report_any,
  output logic                first_valid,
  output logic [CNT_W-1:0]    first_idx,
  output logic [CNT_W-1:0]    symbol_count
);

  localparam logic [ADDR_W:0] N_LIM = (ADDR_W + 1)'(N_STATES);

  logic                start_of_data;
  logic                addr_ok;
  logic                wr_ok;
  logic [N_STATES-1:0] report_mask;
  ste_cfg_t            cfg_wr;

  // Config port has no ready: a strobe is accepted only while run is low and
  // the address is in range; anything else is dropped and flagged on cfg_err.
  always_comb begin
    addr_ok       = ({1'b0, cfg_addr} < N_LIM);
    wr_ok         = cfg_we & ~run & addr_ok;
    cfg_wr        = CFG_EMPTY;
    cfg_wr.lo     = STE_SYM_W'(cfg_lo);
    cfg_wr.hi     = STE_SYM_W'(cfg_hi);
    cfg_wr.start  = start_t'(cfg_start);
    cfg_wr.report = cfg_report;
    cfg_wr.pred   = STE_MAX_N'(cfg_pred);
  end

  for (genvar i = 0; i < N_STATES; i++) begin : g_ste
    ltl_ste_cell #(
      .N_STATES (N_STATES),
      .SYMBOL_W (SYMBOL_W)
    ) u_cell (
      .clk           (clk),
      .reset         (reset),
      .restart       (restart),
      .run           (run),
      .start_of_data (start_of_data),
      .symbols       (symbols),
      .cfg_we        (wr_ok && (cfg_addr == ADDR_W'(i))),
      .cfg_wr        (cfg_wr),
      .active_vec    (active),
      .active        (active[i]),
      .report_en     (report_mask[i])
    );
  end

  assign report     = active & report_mask;
  assign report_any = |report;

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we & (run | ~addr_ok);
    end
  end

  // The counter is already one ahead when report_any is seen, hence the -1.
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      start_of_data <= 1'b1;
      symbol_count  <= '0;
      first_valid   <= 1'b0;
      first_idx     <= '0;
    end else begin
      if (run) begin
        start_of_data <= 1'b0;
        if (symbol_count != '1) begin
          symbol_count <= symbol_count + CNT_W'(1);
        end
      end
      if (report_any && !first_valid) begin
        first_valid <= 1'b1;
        first_idx   <= symbol_count - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ltl_automata_engine.sv
// Directed bench for ltl_automata_engine (12 elements so an out-of-range
// address is representable on the 4-bit cfg_addr port).
module tb_ltl_automata_engine;

  localparam int N  = 12;
  localparam int SW = 8;
  localparam int CW = 32;
  localparam int AW = $clog2(N);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          run = 1'b0;
  logic [SW-1:0] symbols = '0;
  logic          restart = 1'b0;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [SW-1:0] cfg_lo = '0;
  logic [SW-1:0] cfg_hi = '0;
  logic [1:0]    cfg_start = '0;
  logic          cfg_report = 1'b0;
  logic [N-1:0]  cfg_pred = '0;
  logic          cfg_err;
  logic [N-1:0]  active;
  logic [N-1:0]  report;
  logic          report_any;
  logic          first_valid;
  logic [CW-1:0] first_idx;
  logic [CW-1:0] symbol_count;

  int passed = 0;
  int total  = 0;

  ltl_automata_engine #(.N_STATES(N), .SYMBOL_W(SW), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .symbols      (symbols),
    .restart      (restart),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_lo       (cfg_lo),
    .cfg_hi       (cfg_hi),
    .cfg_start    (cfg_start),
    .cfg_report   (cfg_report),
    .cfg_pred     (cfg_pred),
    .cfg_err      (cfg_err),
    .active       (active),
    .report       (report),
    .report_any   (report_any),
    .first_valid  (first_valid),
    .first_idx    (first_idx),
    .symbol_count (symbol_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic feed(input logic [SW-1:0] s);
    run = 1'b1;
    symbols = s;
    tick();
    run = 1'b0;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  task automatic cfg_write(input logic [AW-1:0] a, input logic [SW-1:0] lo,
                           input logic [SW-1:0] hi, input logic [1:0] st,
                           input logic rep, input logic [N-1:0] pred);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_lo = lo;
    cfg_hi = hi;
    cfg_start = st;
    cfg_report = rep;
    cfg_pred = pred;
    tick();
    cfg_we = 1'b0;
  endtask

  initial begin
    logic any_active;
    logic any_report;

    // Reset defaults
    tick();
    tick();
    reset = 1'b0;
    check("rst_active", active, 0);
    check("rst_first_valid", first_valid, 0);
    check("rst_first_idx", first_idx, 0);
    check("rst_count", symbol_count, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_report_any", report_any, 0);

    any_active = 1'b0;
    any_report = 1'b0;
    for (int s = 0; s < 256; s++) begin
      feed(SW'(s));
      any_active |= |active;
      any_report |= report_any;
    end
    check("empty_cfg_active", any_active, 0);
    check("empty_cfg_report", any_report, 0);
    check("empty_cfg_count", symbol_count, 256);

    // Start-of-data + self-loop chain
    do_restart();
    check("restart_count", symbol_count, 0);
    cfg_write(0, 8'd0, 8'd63, 2'd1, 1'b0, 12'h001);
    check("cfg_ok_err", cfg_err, 0);
    cfg_write(1, 8'd64, 8'd127, 2'd1, 1'b1, 12'h001);
    feed(8'd10);
    check("chain_a_active", active, 12'h001);
    check("chain_a_report", report_any, 0);
    feed(8'd20);
    check("chain_b_active", active, 12'h001);
    check("chain_b_report", report_any, 0);
    feed(8'd100);
    check("chain_c_active", active, 12'h002);
    check("chain_c_report", report, 12'h002);
    check("chain_c_fv_lag", first_valid, 0);
    tick();
    check("chain_fv", first_valid, 1);
    check("chain_idx", first_idx, 2);
    check("chain_count", symbol_count, 3);

    // Start-of-data only
    do_restart();
    check("sod_restart_active", active, 0);
    check("sod_restart_fv", first_valid, 0);
    feed(8'd100);
    check("sod_active", active, 12'h002);
    tick();
    check("sod_fv", first_valid, 1);
    check("sod_idx", first_idx, 0);
    do_restart();
    feed(8'd200);
    check("nosod_a_active", active, 0);
    feed(8'd100);
    check("nosod_b_active", active, 0);
    check("nosod_report", report_any, 0);
    tick();
    check("nosod_fv", first_valid, 0);

    // All-input start
    cfg_write(2, 8'd128, 8'd191, 2'd2, 1'b1, 12'h000);
    do_restart();
    feed(8'd5);
    check("all_a_active", active, 12'h001);
    feed(8'd150);
    check("all_b_active", active, 12'h004);
    check("all_b_report", report, 12'h004);
    feed(8'd5);
    check("all_c_active", active, 12'h000);
    check("all_c_fv", first_valid, 1);
    check("all_c_idx", first_idx, 1);
    feed(8'd160);
    check("all_d_report", report, 12'h004);
    tick();
    check("all_idx_kept", first_idx, 1);
    check("all_count", symbol_count, 4);

    // Rejected write during run
    run = 1'b1;
    symbols = 8'd5;
    cfg_we = 1'b1;
    cfg_addr = 4'd2;
    cfg_lo = 8'd0;
    cfg_hi = 8'd255;
    cfg_start = 2'd2;
    cfg_report = 1'b1;
    cfg_pred = '0;
    tick();
    run = 1'b0;
    cfg_we = 1'b0;
    check("rej_run_err", cfg_err, 1);
    tick();
    check("rej_run_err_pulse", cfg_err, 0);
    do_restart();
    feed(8'd5);
    check("rej_run_unchanged", active, 12'h001);

    // Rejected out-of-range address, then last valid address
    cfg_write(4'd12, 8'd0, 8'd255, 2'd2, 1'b1, 12'h000);
    check("rej_addr_err", cfg_err, 1);
    do_restart();
    feed(8'd200);
    check("rej_addr_nowrite", active, 0);
    cfg_write(4'd11, 8'd200, 8'd210, 2'd2, 1'b0, 12'h000);
    check("last_addr_err", cfg_err, 0);
    feed(8'd205);
    check("last_addr_active", active, 12'h800);
    check("last_addr_report", report_any, 0);

    // Mid-stream reset clears configuration too
    do_restart();
    feed(8'd30);
    check("pre_reset_active", active, 12'h001);
    reset = 1'b1;
    run = 1'b1;
    symbols = 8'd205;
    tick();
    reset = 1'b0;
    run = 1'b0;
    check("mid_rst_active", active, 0);
    check("mid_rst_count", symbol_count, 0);
    check("mid_rst_fv", first_valid, 0);
    feed(8'd30);
    check("mid_rst_cfg_e0", active, 0);
    feed(8'd205);
    check("mid_rst_cfg_e11", active, 0);
    check("mid_rst_count2", symbol_count, 2);

    // restart together with run discards the symbol and re-arms start-of-data
    cfg_write(0, 8'd0, 8'd63, 2'd1, 1'b0, 12'h001);
    do_restart();
    feed(8'd40);
    feed(8'd50);
    check("rr_pre_active", active, 12'h001);
    check("rr_pre_count", symbol_count, 2);
    restart = 1'b1;
    run = 1'b1;
    symbols = 8'd10;
    tick();
    restart = 1'b0;
    run = 1'b0;
    check("rr_active", active, 0);
    check("rr_count", symbol_count, 0);
    feed(8'd10);
    check("rr_sod_active", active, 12'h001);
    check("rr_sod_count", symbol_count, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
